// File: rtl/alu_pkg.sv
// Shared opcode constants, FSM state type and default settle time for the ALU issue block.
package alu_pkg;

  localparam logic [2:0] OpNop     = 3'b000;
  localparam logic [2:0] OpAdd     = 3'b001;
  localparam logic [2:0] OpSub     = 3'b010;
  localparam logic [2:0] OpAnd     = 3'b011;
  localparam logic [2:0] OpOr      = 3'b100;
  localparam logic [2:0] OpXor     = 3'b101;
  localparam logic [2:0] OpNot     = 3'b110;
  localparam logic [2:0] OpIllegal = 3'b111;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StCapture,
    StWb
  } state_e;

  localparam int unsigned AluSettleDefault = 2;

endpackage

// File: rtl/alu_flag_calc.sv
// Combinational next-value calculation for the N/Z/V status flags.
module alu_flag_calc
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0] data,
  input  logic              overflow,
  input  logic [2:0]        opcode,
  output logic              n,
  output logic              z,
  output logic              v
);

  always_comb begin
    n = data[DATA_W-1];
    z = (data == '0);
    // Only arithmetic ops carry a meaningful overflow; logical ops clear V.
    v = overflow && ((opcode == OpAdd) || (opcode == OpSub));
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Execute-stage sequencer: issues decoded ops to the ALU, captures results, drives writeback.
// Optional build macro ALU_ISSUE_PERF_EN adds saturating perf_ops/perf_ovf counters.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned ALU_SETTLE = AluSettleDefault
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_opcode,
  input  logic [DATA_W-1:0] in_op1,
  input  logic [DATA_W-1:0] in_op2,
  input  logic [REG_AW-1:0] in_rd,
  output logic              alu_en,
  output logic [2:0]        alu_opcode,
  output logic [DATA_W-1:0] alu_operand1,
  output logic [DATA_W-1:0] alu_operand2,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_overflow,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [REG_AW-1:0] wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              flag_n,
  output logic              flag_z,
  output logic              flag_v,
  output logic              illegal_op,
  output logic              busy
`ifdef ALU_ISSUE_PERF_EN
  ,
  output logic [31:0]       perf_ops,
  output logic [15:0]       perf_ovf
`endif
);

  localparam int unsigned CntW = (ALU_SETTLE > 1) ? $clog2(ALU_SETTLE) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(ALU_SETTLE - 1);

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [2:0]          op_q;
  logic [DATA_W-1:0]   opa_q, opb_q, data_q;
  logic [REG_AW-1:0]   rd_q;
  logic                ovf_q;
  logic                n_q, z_q, v_q;
  logic                illegal_q;
  logic                n_next, z_next, v_next;
  logic                accept, load, wb_fire;

  assign accept  = (state_q == StIdle) && in_valid;
  assign load    = accept && (in_opcode != OpNop) && (in_opcode != OpIllegal);
  assign wb_fire = (state_q == StWb) && wb_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (load) state_d = StIssue;
      end
      StIssue: begin
        if (cnt_q == CntLast) state_d = StCapture;
        else                  cnt_d   = cnt_q + 1'b1;
      end
      StCapture: state_d = StWb;
      StWb:      if (wb_ready) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  alu_flag_calc #(
    .DATA_W(DATA_W)
  ) u_flag_calc (
    .data    (data_q),
    .overflow(ovf_q),
    .opcode  (op_q),
    .n       (n_next),
    .z       (z_next),
    .v       (v_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      op_q      <= OpNop;
      opa_q     <= '0;
      opb_q     <= '0;
      rd_q      <= '0;
      data_q    <= '0;
      ovf_q     <= 1'b0;
      n_q       <= 1'b0;
      z_q       <= 1'b0;
      v_q       <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      illegal_q <= accept && (in_opcode == OpIllegal);
      if (load) begin
        op_q  <= in_opcode;
        opa_q <= in_op1;
        opb_q <= in_op2;
        rd_q  <= in_rd;
      end
      if (state_q == StCapture) begin
        data_q <= alu_result;
        ovf_q  <= alu_overflow;
      end
      if (wb_fire) begin
        n_q <= n_next;
        z_q <= z_next;
        v_q <= v_next;
      end
    end
  end

`ifdef ALU_ISSUE_PERF_EN
  logic [31:0] ops_q;
  logic [15:0] ovf_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ops_q     <= '0;
      ovf_cnt_q <= '0;
    end else if (wb_fire) begin
      if (ops_q != '1) ops_q <= ops_q + 1'b1;
      if (v_next && (ovf_cnt_q != '1)) ovf_cnt_q <= ovf_cnt_q + 1'b1;
    end
  end

  assign perf_ops = ops_q;
  assign perf_ovf = ovf_cnt_q;
`endif

  assign in_ready     = (state_q == StIdle);
  assign busy         = (state_q != StIdle);
  assign alu_en       = (state_q == StIssue) || (state_q == StCapture);
  assign alu_opcode   = op_q;
  assign alu_operand1 = opa_q;
  assign alu_operand2 = opb_q;
  assign wb_valid     = (state_q == StWb);
  assign wb_rd        = rd_q;
  assign wb_data      = data_q;
  assign flag_n       = n_q;
  assign flag_z       = z_q;
  assign flag_v       = v_q;
  assign illegal_op   = illegal_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl: random and directed ops against a signed-arithmetic model.
module tb_alu_issue_ctrl;

  localparam logic [2:0] NOP = 3'd0, ADD = 3'd1, SUB = 3'd2, AND = 3'd3;
  localparam logic [2:0] OR = 3'd4, XOR = 3'd5, NOT = 3'd6, ILL = 3'd7;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_opcode = 3'd0;
  logic [31:0] in_op1 = '0, in_op2 = '0;
  logic [4:0]  in_rd = '0;
  logic        alu_en;
  logic [2:0]  alu_opcode;
  logic [31:0] alu_operand1, alu_operand2;
  logic [31:0] alu_result = '0;
  logic        alu_overflow = 1'b0;
  logic        wb_valid;
  logic        wb_ready = 1'b1;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        flag_n, flag_z, flag_v, illegal_op, busy;
`ifdef ALU_ISSUE_PERF_EN
  logic [31:0] perf_ops;
  logic [15:0] perf_ovf;
`endif

  alu_issue_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_opcode   (in_opcode),
    .in_op1      (in_op1),
    .in_op2      (in_op2),
    .in_rd       (in_rd),
    .alu_en      (alu_en),
    .alu_opcode  (alu_opcode),
    .alu_operand1(alu_operand1),
    .alu_operand2(alu_operand2),
    .alu_result  (alu_result),
    .alu_overflow(alu_overflow),
    .wb_valid    (wb_valid),
    .wb_ready    (wb_ready),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .flag_n      (flag_n),
    .flag_z      (flag_z),
    .flag_v      (flag_v),
    .illegal_op  (illegal_op),
    .busy        (busy)
`ifdef ALU_ISSUE_PERF_EN
    ,
    .perf_ops    (perf_ops),
    .perf_ovf    (perf_ovf)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Registered ALU stand-in; garbage overflow on logical ops checks that V is cleared.
  function automatic logic [32:0] alu_fn(input logic [2:0] op, input logic [31:0] a, b,
                                         input logic junk);
    logic [31:0] r;
    logic        o;
    o = junk;
    case (op)
      ADD: begin r = a + b; o = (a[31] == b[31]) && (r[31] != a[31]); end
      SUB: begin r = a - b; o = (a[31] != b[31]) && (r[31] != a[31]); end
      AND: r = a & b;
      OR:  r = a | b;
      XOR: r = a ^ b;
      NOT: r = ~a;
      default: r = 32'hBADBAD00;
    endcase
    return {o, r};
  endfunction

  always @(posedge clk) begin
    if (alu_en)
      {alu_overflow, alu_result} <= alu_fn(alu_opcode, alu_operand1, alu_operand2,
                                           1'($urandom_range(0, 1)));
    else
      {alu_overflow, alu_result} <= {1'b1, 32'hDEADBEEF};
  end

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic [2:0]  nzv;
    int          exp_cyc;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0, n_fail = 0;
  int   exp_ill = 0, ill_seen = 0;
  int   model_ops = 0, model_ovf = 0;
  int   wb_mode = 1;  // 0 random, 1 high, 2 low

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: signed arithmetic on wide integers, no bit tricks.
  task automatic model(input logic [2:0] op, input logic [31:0] a, b,
                       output logic [31:0] r, output logic v);
    longint sa, sb, s;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    v  = 1'b0;
    r  = '0;
    case (op)
      ADD, SUB: begin
        s = (op == ADD) ? sa + sb : sa - sb;
        r = 32'(s);
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      AND: r = a & b;
      OR:  r = a | b;
      XOR: r = a ^ b;
      NOT: r = ~a;
      default: r = '0;
    endcase
  endtask

  initial begin
    forever begin
      @(negedge clk);
      wb_ready = (wb_mode == 1) ? 1'b1 :
                 (wb_mode == 2) ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  logic [2:0] cur_nzv = '0;
  bit         seen_first = 0;

  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        q.delete();
        cur_nzv    = '0;
        seen_first = 0;
        model_ops  = 0;
        model_ovf  = 0;
      end else begin
        check("flags_nzv", 64'({flag_n, flag_z, flag_v}), 64'(cur_nzv));
        if (illegal_op) ill_seen++;
        if (wb_valid) begin
          if (q.size() == 0) begin
            check("spurious_wb_valid", 64'(wb_valid), 64'd0);
          end else begin
            if (!seen_first) begin
              check("wb_latency_cycle", 64'(cyc), 64'(q[0].exp_cyc));
              seen_first = 1;
            end
            check("wb_rd", 64'(wb_rd), 64'(q[0].rd));
            check("wb_data", 64'(wb_data), 64'(q[0].data));
            if (wb_ready) begin
              cur_nzv = q[0].nzv;
              model_ops++;
              if (q[0].nzv[0]) model_ovf++;
              void'(q.pop_front());
              seen_first = 0;
            end
          end
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, b, input logic [4:0] rd);
    int          waited = 0;
    logic [31:0] r;
    logic        v;
    in_valid = 1'b1; in_opcode = op; in_op1 = a; in_op2 = b; in_rd = rd;
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      check("accept_timeout", 64'(in_ready), 64'd1);
      in_valid = 1'b0;
      return;
    end
    if (op == ILL) exp_ill++;
    else if (op != NOP) begin
      model(op, a, b, r, v);
      q.push_back('{rd: rd, data: r, nzv: {r[31], r == 32'd0, v}, exp_cyc: cyc + 4});
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || busy) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) check("drain_timeout", 64'(q.size()), 64'd0);
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    check({tag, "_alu_en"}, 64'(alu_en), 64'd0);
    check({tag, "_alu_opcode"}, 64'(alu_opcode), 64'd0);
    check({tag, "_alu_operands"}, {alu_operand1, alu_operand2}, 64'd0);
    check({tag, "_wb_valid"}, 64'(wb_valid), 64'd0);
    check({tag, "_wb_rd_data"}, 64'({wb_rd, wb_data}), 64'd0);
    check({tag, "_flags_ill_busy"}, 64'({flag_n, flag_z, flag_v, illegal_op, busy}), 64'd0);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    wb_mode = 1;
    issue(ADD, 32'h7FFF_FFFF, 32'h0000_0001, 5'd3);
    drain();
    check("add_ovf_flags", 64'({flag_n, flag_z, flag_v}), 64'b101);
    issue(SUB, 32'd5, 32'd5, 5'd4);
    issue(AND, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd5);
    drain();

    wb_mode = 2;
    issue(NOT, 32'h0, 32'h1234_5678, 5'd9);
    repeat (10) @(negedge clk);
    check("stall_in_ready", 64'(in_ready), 64'd0);
    check("stall_wb_valid", 64'(wb_valid), 64'd1);
    wb_mode = 1;
    drain();

    issue(NOP, 32'd1, 32'd2, 5'd1);
    issue(ILL, 32'd3, 32'd4, 5'd2);
    repeat (3) @(negedge clk);
    check("illegal_pulses", 64'(ill_seen), 64'(exp_ill));

    issue(ADD, 32'd1, 32'd1, 5'd7);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("midop_reset");
    rst = 1'b0;
    @(negedge clk);
    issue(XOR, 32'hAAAA_5555, 32'hFFFF_0000, 5'd11);
    drain();

    wb_mode = 0;
    for (int i = 0; i < 60; i++) begin
      logic [2:0] op;
      int         sel;
      sel = $urandom_range(0, 9);
      op  = (sel == 0) ? NOP : (sel == 1) ? ILL : 3'($urandom_range(1, 6));
      issue(op, pick_operand(), pick_operand(), 5'($urandom));
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
    wb_mode = 1;
    drain();
    check("illegal_pulses_total", 64'(ill_seen), 64'(exp_ill));
`ifdef ALU_ISSUE_PERF_EN
    check("perf_ops", 64'(perf_ops), 64'(model_ops));
    check("perf_ovf", 64'(perf_ovf), 64'(model_ovf));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
